piso_serializer: RTL
====================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter WIDTH, default 4, sets parallel word width; legal values are 2..16.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 resetn  input  1  reset, asynchronous, active-low.
REQ-004 clear  input  1  synchronous abort; discards holding buffer and word in flight.
REQ-005 data_in  input  WIDTH  parallel word to serialize.
REQ-006 msb_first  input  1  bit order for the word accepted this cycle: 1 = MSB first, 0 = LSB first.
REQ-007 in_valid  input  1  data_in/msb_first valid.
REQ-008 in_ready  output  1  block can accept a word this cycle.
REQ-009 ser_out  output  1  serial bit currently presented.
REQ-010 ser_valid  output  1  ser_out holds a valid bit.
REQ-011 ser_ready  input  1  downstream consumes ser_out this cycle.
REQ-012 ser_last  output  1  ser_out is the final bit of the current word.
REQ-013 busy  output  1  high when the holding buffer is occupied or a word is in flight.

Function
REQ-014 Input transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; data_in and msb_first go into a one-entry holding buffer (hold_data, hold_order, hold_valid).
REQ-015 in_ready SHALL equal !hold_valid (combinational, no dependency on in_valid).
REQ-016 Shifter FSM SHALL have two states: IDLE (ser_valid=0) and SHIFT (ser_valid=1).
REQ-017 IDLE with hold_valid=1 SHALL load the shifter from the buffer on the next edge, clear hold_valid, set bit counter to 0, and enter SHIFT.
REQ-018 Latency: a word accepted at edge N SHALL present its first bit on ser_out after edge N+1.
REQ-019 The shifter register and order flag SHALL be latched at load; msb_first changes afterward SHALL NOT affect the word in flight.
REQ-020 A bit transfer SHALL occur on an edge with ser_valid=1 and ser_ready=1; only then SHALL the shifter advance one position and the counter increment.
REQ-021 With ser_ready=0, ser_out, ser_last and the counter SHALL hold unchanged.
REQ-022 ser_out SHALL be shifter[WIDTH-1] when MSB-first and shifter[0] when LSB-first.
REQ-023 ser_last SHALL be 1 exactly when in SHIFT and counter = WIDTH-1.
REQ-024 On a transfer of the last bit: if hold_valid=1, the next word SHALL load on that same edge (no idle gap); otherwise the FSM SHALL return to IDLE.
REQ-025 The counter SHALL be $clog2(WIDTH) bits wide and never exceed WIDTH-1.
REQ-026 An input transfer and a buffer-to-shifter load on the same edge cannot coincide because in_ready=0 whenever hold_valid=1; no other priority rule is required.
REQ-027 Sustained throughput SHALL be one word per WIDTH cycles with ser_ready held at 1.
REQ-028 clear=1 SHALL, on the next edge, force IDLE, hold_valid=0, counter=0 and shifter=0, overriding any input transfer or load on that edge.
REQ-029 busy SHALL equal hold_valid OR (state == SHIFT).

Reset
REQ-030 resetn=0 SHALL immediately force the FSM to IDLE, and set the shifter, counter, hold_data, hold_order and hold_valid to 0.
REQ-031 During reset the outputs SHALL be: ser_out=0, ser_valid=0, ser_last=0, busy=0, in_ready=1.
REQ-032 Reset asserted mid-word SHALL discard both the in-flight and buffered words; after release the block SHALL start in IDLE, ready for a new word.

Verification (WIDTH=4)
REQ-033 Reset: hold resetn=0 with random inputs -> ser_valid=0, ser_out=0, busy=0, in_ready=1.
REQ-034 Single word 4'b1010, msb_first=1, ser_ready=1, accepted at edge N -> ser_out = 1,0,1,0 in cycles N+1..N+4, with ser_last=1 only in N+4 and ser_valid=0 in N+5.
REQ-035 Same word with msb_first=0 -> ser_out = 0,1,0,1.
REQ-036 Back-to-back 1010 (MSB-first) then 0110 (LSB-first) offered continuously -> 8 contiguous ser_valid cycles carrying 1,0,1,0,0,1,1,0; in_ready=0 while the second word waits in the buffer.
REQ-037 Backpressure: ser_ready=0 for 3 cycles after the 2nd bit of 1010 -> ser_out holds 1 and ser_last stays 0 for those cycles; the stream then resumes with 1,0.
REQ-038 resetn pulsed low after the 2nd bit, with a second word buffered -> outputs go to zero asynchronously, no further bits are emitted, and in_ready=1 after release; clear=1 in the same situation gives the same result at the next edge.

Source files
------------

// File: rtl/piso_serializer_if.sv
// Parallel-in / serial-out handshake bundle: word input side plus serial output side.
interface piso_serializer_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] data_in;
    logic             msb_first;
    logic             in_valid;
    logic             in_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_ready;
    logic             ser_last;

    // Producer of words / consumer of serial bits.
    modport master (
        output data_in,
        output msb_first,
        output in_valid,
        output ser_ready,
        input  in_ready,
        input  ser_out,
        input  ser_valid,
        input  ser_last
    );

    // The serializer itself.
    modport slave (
        input  data_in,
        input  msb_first,
        input  in_valid,
        input  ser_ready,
        output in_ready,
        output ser_out,
        output ser_valid,
        output ser_last
    );
endinterface

// File: rtl/piso_serializer.sv
// Serializer with a one-entry holding buffer in front of a shift register.
// Words are emitted MSB- or LSB-first as selected when each word is accepted;
// a buffered word loads on the same edge as the last bit of the previous one.
module piso_serializer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                clear,
    output logic                busy,
    piso_serializer_if.slave    bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   shifter;
    logic               order;
    logic [CNT_W-1:0]   counter;
    logic [WIDTH-1:0]   hold_data;
    logic               hold_order;
    logic               hold_valid;

    logic               in_fire;
    logic               bit_xfer;
    logic               last_xfer;
    logic               load;
    logic [WIDTH-1:0]   shifted;

    // Handshake qualifiers and next shifter contents.
    always_comb begin
        in_fire   = 1'b0;
        bit_xfer  = 1'b0;
        last_xfer = 1'b0;
        load      = 1'b0;
        shifted   = shifter;

        in_fire   = bus.in_valid & ~hold_valid;
        bit_xfer  = (state == SHIFT) & bus.ser_ready;
        last_xfer = bit_xfer & (counter == LAST_CNT);
        // Load from the buffer when idle, or back-to-back on the final bit.
        load      = hold_valid & ((state == IDLE) | last_xfer);
        shifted   = order ? {shifter[WIDTH-2:0], 1'b0}
                          : {1'b0, shifter[WIDTH-1:1]};
    end

    // Holding buffer, shifter FSM and bit counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            shifter    <= '0;
            order      <= 1'b0;
            counter    <= '0;
            hold_data  <= '0;
            hold_order <= 1'b0;
            hold_valid <= 1'b0;
        end else if (clear) begin
            // Abort: drop the buffered word and the word in flight.
            state      <= IDLE;
            shifter    <= '0;
            order      <= 1'b0;
            counter    <= '0;
            hold_valid <= 1'b0;
        end else begin
            // in_fire needs an empty buffer and load needs a full one,
            // so the two never occur on the same edge.
            if (in_fire) begin
                hold_data  <= bus.data_in;
                hold_order <= bus.msb_first;
                hold_valid <= 1'b1;
            end else if (load) begin
                hold_valid <= 1'b0;
            end

            if (load) begin
                shifter <= hold_data;
                order   <= hold_order;
                counter <= '0;
                state   <= SHIFT;
            end else if (bit_xfer) begin
                shifter <= shifted;
                if (last_xfer) begin
                    counter <= '0;
                    state   <= IDLE;
                end else begin
                    counter <= counter + CNT_W'(1);
                end
            end
        end
    end

    // Outputs decoded directly from registered state.
    assign bus.in_ready  = ~hold_valid;
    assign bus.ser_valid = (state == SHIFT);
    assign bus.ser_out   = order ? shifter[WIDTH-1] : shifter[0];
    assign bus.ser_last  = (state == SHIFT) && (counter == LAST_CNT);
    assign busy          = hold_valid | (state == SHIFT);

    // Counter stays within the word and rests at zero when idle.
    always_ff @(posedge clk) begin
        if (resetn) begin
            assert (counter <= LAST_CNT);
            assert ((state == SHIFT) || (counter == '0));
        end
    end

endmodule
